fpf_rx_decoder_16: RTL and testbench

Pipelined receive-side decoder for the 16-wire forbidden-pattern-free (FPF) Fibonacci-coded TSV link. It samples the 16 TSV lines, checks each word for forbidden 010/101 triplets, and converts the Fibonacci-weighted codeword to a 12-bit binary value in the range 0..2583. It sits at the far end of the TSV bundle, opposite the FPF encoder, and replaces the combinational FNS decoder wherever the receive path must be registered and monitored.

---
 rtl/fpf_rx_decoder_16.sv | 149 ++++++++++++++
 tb/tb_fpf_rx_decoder_16.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fpf_rx_decoder_16.sv
// fpf_rx_decoder_16: three-stage receive decoder for the 16-wire FPF
// Fibonacci-coded TSV link. It checks each word for 010/101 triplets and
// converts the Fibonacci-weighted codeword to binary (0..2583). It also
// keeps a sticky error flag and a saturating error counter.
module fpf_rx_decoder_16 #(
  parameter int NBIT = 16,
  parameter int DW   = 12
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NBIT-1:0] tsv_in,
  input  logic            in_valid,
  input  logic            clr_err,
  output logic [DW-1:0]   data_out,
  output logic            out_valid,
  output logic            pat_err,
  output logic            err_sticky,
  output logic [15:0]     err_count
);

  // Fibonacci weight of wire k (W0 = W1 = 1)
  function automatic logic [9:0] fib_weight(input int k);
    case (k)
      0:       return 10'd1;
      1:       return 10'd1;
      2:       return 10'd2;
      3:       return 10'd3;
      4:       return 10'd5;
      5:       return 10'd8;
      6:       return 10'd13;
      7:       return 10'd21;
      8:       return 10'd34;
      9:       return 10'd55;
      10:      return 10'd89;
      11:      return 10'd144;
      12:      return 10'd233;
      13:      return 10'd377;
      14:      return 10'd610;
      15:      return 10'd987;
      default: return 10'd0;
    endcase
  endfunction

  // Stage 1 registers
  logic [NBIT-1:0] tsv_q;
  logic            v1_q;

  // Stage 2 registers. The low half peaks at 54, but the high half
  // reaches 2529 and therefore needs a full 12-bit register.
  logic [10:0]     lo_sum_q, lo_sum_d;
  logic [11:0]     hi_sum_q, hi_sum_d;
  logic            flag_q, flag_d;
  logic            v2_q;

  // Stage 3 and error-monitor registers
  logic [DW-1:0]   data_out_q, data_out_d;
  logic            out_valid_q, pat_err_q, pat_err_d;
  logic            err_sticky_q, err_sticky_d;
  logic [15:0]     err_count_q, err_count_d;

  // Stage 2 logic: forbidden-triplet scan over all 14 windows,
  // plus the two Fibonacci partial sums
  always_comb begin
    flag_d   = 1'b0;
    lo_sum_d = '0;
    hi_sum_d = '0;
    for (int j = 0; j < NBIT - 2; j++) begin
      if (tsv_q[j +: 3] == 3'b101 || tsv_q[j +: 3] == 3'b010) begin
        flag_d = 1'b1;
      end
    end
    for (int k = 0; k < 8; k++) begin
      if (tsv_q[k]) begin
        lo_sum_d = lo_sum_d + 11'(fib_weight(k));
      end
    end
    for (int k = 8; k < NBIT; k++) begin
      if (tsv_q[k]) begin
        hi_sum_d = hi_sum_d + 12'(fib_weight(k));
      end
    end
  end

  // Stage 3 logic: final add. pat_err is qualified by the valid bit so
  // that it never shows up without out_valid.
  always_comb begin
    data_out_d = 12'(lo_sum_q) + hi_sum_q;
    pat_err_d  = v2_q & flag_q;
  end

  // Error monitor: clr_err wins over a coincident flagged word, and
  // the counter sticks at all-ones instead of wrapping
  always_comb begin
    err_count_d  = err_count_q;
    err_sticky_d = err_sticky_q;
    if (clr_err) begin
      err_count_d  = '0;
      err_sticky_d = 1'b0;
    end else if (out_valid_q && pat_err_q) begin
      err_sticky_d = 1'b1;
      if (err_count_q != 16'hFFFF) begin
        err_count_d = err_count_q + 16'd1;
      end
    end
  end

  // All pipeline and monitor state. The data registers load only with
  // their valid bit; the valid bits themselves advance every cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tsv_q        <= '0;
      v1_q         <= 1'b0;
      lo_sum_q     <= '0;
      hi_sum_q     <= '0;
      flag_q       <= 1'b0;
      v2_q         <= 1'b0;
      data_out_q   <= '0;
      out_valid_q  <= 1'b0;
      pat_err_q    <= 1'b0;
      err_sticky_q <= 1'b0;
      err_count_q  <= '0;
    end else begin
      v1_q        <= in_valid;
      v2_q        <= v1_q;
      out_valid_q <= v2_q;
      pat_err_q   <= pat_err_d;
      if (in_valid) begin
        tsv_q <= tsv_in;
      end
      if (v1_q) begin
        lo_sum_q <= lo_sum_d;
        hi_sum_q <= hi_sum_d;
        flag_q   <= flag_d;
      end
      if (v2_q) begin
        data_out_q <= data_out_d;
      end
      err_sticky_q <= err_sticky_d;
      err_count_q  <= err_count_d;
    end
  end

  assign data_out   = data_out_q;
  assign out_valid  = out_valid_q;
  assign pat_err    = pat_err_q;
  assign err_sticky = err_sticky_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_fpf_rx_decoder_16.sv
// tb_fpf_rx_decoder_16: scoreboard bench for the FPF receive decoder.
// Expected words are queued as they are driven and popped when the
// valid-pipeline model says they should emerge.
module tb_fpf_rx_decoder_16;

  logic        clock;
  logic        reset;
  logic [15:0] tsv_in;
  logic        in_valid;
  logic        clr_err;
  logic [11:0] data_out;
  logic        out_valid;
  logic        pat_err;
  logic        err_sticky;
  logic [15:0] err_count;

  typedef struct {
    logic [11:0] data;
    logic        pat;
  } exp_t;

  exp_t        sb[$];
  logic [2:0]  vPipe;
  logic        prevFlag;
  logic [15:0] expCount;
  logic        expSticky;
  int          checks;
  int          fails;

  fpf_rx_decoder_16 dut (
    .clock      (clock),
    .reset      (reset),
    .tsv_in     (tsv_in),
    .in_valid   (in_valid),
    .clr_err    (clr_err),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .pat_err    (pat_err),
    .err_sticky (err_sticky),
    .err_count  (err_count)
  );

  // 100 MHz free-running clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference Fibonacci decode built from the recurrence
  function automatic logic [11:0] modelDecode(input logic [15:0] w);
    int sum, cur, prev, t;
    sum  = 0;
    cur  = 1;
    prev = 0;
    for (int k = 0; k < 16; k++) begin
      if (w[k]) sum += cur;
      t    = cur + prev;
      prev = cur;
      cur  = t;
    end
    return 12'(sum);
  endfunction

  // Reference forbidden-pattern scan
  function automatic logic modelFlag(input logic [15:0] w);
    logic [2:0] tri3;
    for (int j = 0; j < 14; j++) begin
      tri3 = w[j +: 3];
      if (tri3 == 3'b101 || tri3 == 3'b010) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Random codeword free of 010/101: every run after the first is at
  // least two bits long
  function automatic logic [15:0] makeClean();
    logic [15:0] w;
    logic        bitVal;
    int          pos, len;
    w      = '0;
    bitVal = 1'($urandom_range(0, 1));
    pos    = 0;
    while (pos < 16) begin
      len = (pos == 0) ? $urandom_range(1, 4) : $urandom_range(2, 4);
      for (int i = 0; i < len; i++) begin
        if (pos < 16) w[pos] = bitVal;
        pos++;
      end
      bitVal = ~bitVal;
    end
    return w;
  endfunction

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Drives one cycle of input, steps past the edge, advances the models
  // and checks every output against them
  task automatic applyStimulus(input logic v, input logic [15:0] w,
                               input logic clr);
    exp_t e;
    tsv_in   = w;
    in_valid = v;
    clr_err  = clr;
    if (v) sb.push_back('{data: modelDecode(w), pat: modelFlag(w)});
    @(posedge clock);
    #1;
    if (clr) begin
      expCount  = '0;
      expSticky = 1'b0;
    end else if (prevFlag) begin
      expSticky = 1'b1;
      if (expCount != 16'hFFFF) expCount = expCount + 16'd1;
    end
    vPipe = {vPipe[1:0], v};
    checkOutput("out_valid", 32'(out_valid), 32'(vPipe[2]));
    if (vPipe[2]) begin
      if (sb.size() == 0) begin
        checkOutput("sb_underflow", 32'(sb.size()), 32'd1);
        prevFlag = 1'b0;
      end else begin
        e = sb.pop_front();
        checkOutput("data_out", 32'(data_out), 32'(e.data));
        checkOutput("pat_err", 32'(pat_err), 32'(e.pat));
        prevFlag = e.pat;
      end
    end else begin
      checkOutput("pat_err_idle", 32'(pat_err), 32'd0);
      prevFlag = 1'b0;
    end
    checkOutput("err_count", 32'(err_count), 32'(expCount));
    checkOutput("err_sticky", 32'(err_sticky), 32'(expSticky));
  endtask

  // Asserts reset away from an edge and checks every output is cleared
  task automatic holdReset(input int cycles);
    in_valid = 1'b0;
    clr_err  = 1'b0;
    reset    = 1'b1;
    #1;
    for (int i = 0; i <= cycles; i++) begin
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_data_out", 32'(data_out), 32'd0);
      checkOutput("rst_pat_err", 32'(pat_err), 32'd0);
      checkOutput("rst_err_sticky", 32'(err_sticky), 32'd0);
      checkOutput("rst_err_count", 32'(err_count), 32'd0);
      if (i < cycles) begin
        @(posedge clock);
        #1;
      end
    end
    reset     = 1'b0;
    sb.delete();
    vPipe     = '0;
    prevFlag  = 1'b0;
    expCount  = '0;
    expSticky = 1'b0;
  endtask

  // Main sequence
  initial begin
    checks    = 0;
    fails     = 0;
    tsv_in    = '0;
    in_valid  = 1'b0;
    clr_err   = 1'b0;
    reset     = 1'b0;
    vPipe     = '0;
    prevFlag  = 1'b0;
    expCount  = '0;
    expSticky = 1'b0;
    @(posedge clock);
    #1;
    holdReset(2);

    $display("[TB] basic decode");
    applyStimulus(1'b1, 16'h0000, 1'b0);
    applyStimulus(1'b1, 16'hFFFF, 1'b0);
    applyStimulus(1'b1, 16'h0003, 1'b0);
    applyStimulus(1'b1, 16'hC000, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("basic_err_count", 32'(err_count), 32'd0);

    $display("[TB] forbidden patterns");
    applyStimulus(1'b1, 16'h0005, 1'b0);
    applyStimulus(1'b1, 16'h0002, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("two_err_count", 32'(err_count), 32'd2);
    checkOutput("two_err_sticky", 32'(err_sticky), 32'd1);
    applyStimulus(1'b1, 16'h4000, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("top_err_count", 32'(err_count), 32'd3);
    applyStimulus(1'b0, 16'h0000, 1'b1);

    $display("[TB] random gaps with clean words");
    for (int i = 0; i < 80; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), makeClean(), 1'b0);
    end
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("clean_err_count", 32'(err_count), 32'd0);

    $display("[TB] reset mid-stream");
    applyStimulus(1'b1, 16'h0005, 1'b0);
    applyStimulus(1'b1, 16'h00FF, 1'b0);
    applyStimulus(1'b1, 16'h3C00, 1'b0);
    holdReset(2);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 16'h0000, 1'b0);
    applyStimulus(1'b1, 16'h0F0F, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 16'h0000, 1'b0);

    $display("[TB] clr_err against coincident error");
    applyStimulus(1'b1, 16'h0002, 1'b0);
    applyStimulus(1'b1, 16'h0005, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("clr_err_count", 32'(err_count), 32'd0);
    checkOutput("clr_err_sticky", 32'(err_sticky), 32'd0);

    $display("[TB] counter saturation");
    for (int i = 0; i < 65536; i++) applyStimulus(1'b1, 16'h0005, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 16'h0000, 1'b0);
    checkOutput("sat_err_count", 32'(err_count), 32'h0000FFFF);
    checkOutput("sat_err_sticky", 32'(err_sticky), 32'd1);
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
